// File: rtl/seq_multiplier_32bit_pkg.sv
// Shared constants and state encoding for the sequential 32x32 multiplier.
package seq_multiplier_32bit_pkg;

  localparam int unsigned MultIter = 32;
  localparam int unsigned MultCntW = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } mult_state_e;

endpackage

// File: rtl/seq_multiplier_32bit_if.sv
// Start/busy/done handshake and operand/result bus of the sequential multiplier.
interface seq_multiplier_32bit_if;

  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  // Requester side
  modport master (
    output start, a, b,
    input  busy, done, product
  );

  // Multiplier side
  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/carry_look_ahead_32bit.sv
// 32-bit adder built from eight 4-bit carry-lookahead blocks, rippling group carries.
module carry_look_ahead_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [8:0]  gc;

  assign g     = a & b;
  assign p     = a ^ b;
  assign gc[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_blk
    logic [3:0] gg;
    logic [3:0] pp;
    logic [4:0] c;

    assign gg   = g[4*i +: 4];
    assign pp   = p[4*i +: 4];
    assign c[0] = gc[i];
    assign c[1] = gg[0] | (pp[0] & c[0]);
    assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
    assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) |
                  (pp[2] & pp[1] & pp[0] & c[0]);
    assign c[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) |
                  (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & c[0]);

    assign sum[4*i +: 4] = pp ^ c[3:0];
    assign gc[i+1]       = c[4];
  end

  assign cout = gc[8];

endmodule

// File: rtl/seq_multiplier_ctrl.sv
// FSM and iteration counter sequencing load, 32 shift-add steps and the done pulse.
module seq_multiplier_ctrl
  import seq_multiplier_32bit_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic load_o,
  output logic shift_o,
  output logic busy_o,
  output logic done_o
);

  mult_state_e         state_q, state_d;
  logic [MultCntW-1:0] cnt_q, cnt_d;
  logic                cnt_last;

  assign cnt_last = (cnt_q == MultCntW'(MultIter - 1));

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and datapath control decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_o  = 1'b0;
    shift_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          load_o  = 1'b1;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        busy_o  = 1'b1;
        shift_o = 1'b1;
        cnt_d   = cnt_q + MultCntW'(1);
        if (cnt_last) state_d = StDone;
      end
      StDone: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = StIdle;
      end
      // Unused encoding recovers to idle
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: rtl/seq_multiplier_32bit.sv
// Unsigned 32x32->64 shift-add multiplier reusing a single 32-bit CLA adder.
module seq_multiplier_32bit
  import seq_multiplier_32bit_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  seq_multiplier_32bit_if.slave       bus
);

  logic [31:0] mcand_q, mcand_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        load;
  logic        shift;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_cout;

  seq_multiplier_ctrl u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .start_i (bus.start),
    .load_o  (load),
    .shift_o (shift),
    .busy_o  (bus.busy),
    .done_o  (bus.done)
  );

  assign add_b = lo_q[0] ? mcand_q : 32'h0;

  carry_look_ahead_32bit u_adder (
    .a    (hi_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand load or one shift-add step; carry-out becomes the new hi MSB
  always_comb begin
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (load) begin
      mcand_d = bus.a;
      hi_d    = '0;
      lo_d    = bus.b;
    end else if (shift) begin
      {hi_d, lo_d} = {add_cout, add_sum, lo_q[31:1]};
    end
  end

  assign bus.product = {hi_q, lo_q};

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Randomized and directed self-checking bench for seq_multiplier_32bit.
module tb_seq_multiplier_32bit;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  seq_multiplier_32bit_if mul_if ();

  seq_multiplier_32bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mul_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return {32'h0, x} * {32'h0, y};
  endfunction

  // One operation: start pulse, optional stray start during CALC, latency/result/idle checks
  task automatic do_mult(input logic [31:0] x, input logic [31:0] y, input int inj);
    int n;
    int extra;
    logic [63:0] exp;
    exp = ref_mul(x, y);
    @(negedge clk);
    mul_if.start = 1'b1;
    mul_if.a     = x;
    mul_if.b     = y;
    @(posedge clk);
    #1;
    check_val("busy_after_start", 64'(mul_if.busy), 64'd1);
    @(negedge clk);
    mul_if.start = 1'b0;
    n = 0;
    while (!mul_if.done && n < 100) begin
      if (n == inj) begin
        mul_if.start = 1'b1;
        mul_if.a     = 32'd100;
        mul_if.b     = 32'd100;
      end
      if (n == inj + 1) mul_if.start = 1'b0;
      @(negedge clk);
      n++;
    end
    check_val("latency", 64'(n), 64'd32);
    check_val("product", mul_if.product, exp);
    check_val("busy_in_done", 64'(mul_if.busy), 64'd1);
    @(negedge clk);
    check_val("done_one_cycle", 64'(mul_if.done), 64'd0);
    check_val("busy_idle", 64'(mul_if.busy), 64'd0);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (mul_if.done) extra++;
      @(negedge clk);
    end
    check_val("no_extra_done", 64'(extra), 64'd0);
    check_val("product_hold", mul_if.product, exp);
  endtask

  initial begin
    int n;
    int k;
    int ndone;
    int t_first;
    int t_second;
    logic [31:0] ra;
    logic [31:0] rb;

    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b1;
    mul_if.start = 1'b0;
    mul_if.a     = '0;
    mul_if.b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("reset_busy", 64'(mul_if.busy), 64'd0);
    check_val("reset_done", 64'(mul_if.done), 64'd0);
    check_val("reset_product", mul_if.product, 64'h0);

    // Directed vectors
    do_mult(32'd3, 32'd5, -1);
    check_val("basic_const", mul_if.product, 64'h0000_0000_0000_000F);
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check_val("carry_const", mul_if.product, 64'hFFFF_FFFE_0000_0001);
    do_mult(32'h0, 32'hDEAD_BEEF, -1);
    do_mult(32'h1234_5678, 32'h1, -1);
    do_mult(32'd7, 32'd6, 9);
    check_val("ignore_start_const", mul_if.product, 64'd42);

    // Reset in the middle of 9*9
    @(negedge clk);
    mul_if.start = 1'b1;
    mul_if.a     = 32'd9;
    mul_if.b     = 32'd9;
    @(negedge clk);
    mul_if.start = 1'b0;
    for (int i = 0; i < 15; i++) @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("midrst_busy", 64'(mul_if.busy), 64'd0);
    check_val("midrst_done", 64'(mul_if.done), 64'd0);
    check_val("midrst_product", mul_if.product, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    do_mult(32'd2, 32'd3, -1);

    // Start held high: back-to-back operations
    @(negedge clk);
    mul_if.start = 1'b1;
    mul_if.a     = 32'd10;
    mul_if.b     = 32'd20;
    @(posedge clk);
    k        = 0;
    ndone    = 0;
    t_first  = -1;
    t_second = -1;
    while (k < 80) begin
      @(negedge clk);
      if (mul_if.done) begin
        ndone++;
        if (ndone == 1) t_first = k;
        if (ndone == 2) t_second = k;
        check_val("b2b_product", mul_if.product, ref_mul(32'd10, 32'd20));
      end
      k++;
    end
    mul_if.start = 1'b0;
    check_val("b2b_count", 64'(ndone), 64'd2);
    check_val("b2b_first", 64'(t_first), 64'd32);
    check_val("b2b_second", 64'(t_second), 64'd66);
    n = 0;
    while (mul_if.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("b2b_drain", 64'(mul_if.busy), 64'd0);

    // Randomized operands, biased toward MSB-set values every other pass
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i[0]) begin
        ra[31] = 1'b1;
        rb[31] = 1'b1;
      end
      do_mult(ra, rb, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
